// File: rtl/phase_shift_modulator.sv
// phase_shift_modulator
// Triple-phase-shift modulator for a dual-active-bridge stage. A half-period
// counter sweeps 0..2N-1. The primary and secondary 3-level commands are
// decoded from that counter using the zero-state widths d1/d2 and the outer
// phase shift phi. New settings arrive through a valid/ready handshake, are
// range-checked, and are parked in a pending set. The pending set becomes the
// active set only at a period wrap, or immediately while idle.
// Optional feature macro: PHASE_RAMP_EN. When it is defined, the active phi
// slews toward the requested phi by at most RAMP_STEP per period.
module phase_shift_modulator #(
    parameter int W = 16
`ifdef PHASE_RAMP_EN
    ,
    parameter int RAMP_STEP = 1
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         en,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] half_period,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W:0]   phi,
    output logic         cfg_err,
    output logic [1:0]   V1,
    output logic [1:0]   V2,
    output logic         period_start,
    output logic         running
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

    localparam logic [W-1:0] N_MIN = W'(2);

    state_t       state_reg, state_next;
    logic [W:0]   cnt_reg, cnt_next;

    logic [W-1:0] pend_n_reg, pend_d1_reg, pend_d2_reg;
    logic [W:0]   pend_phi_reg;
    logic         pend_full_reg;

    logic [W-1:0] act_n_reg, act_d1_reg, act_d2_reg;
    logic [W:0]   act_phi_reg;
    logic         act_loaded_reg;

    logic         cfg_err_reg;
    logic [1:0]   v1_reg, v2_reg, v1_next, v2_next;
    logic         ps_reg, ps_next;

    logic [W:0]   two_n, last_cnt, half_last, cnt_inc, sec_pos;
    logic         at_wrap, at_half, xfer, cfg_ok, promote;

`ifdef PHASE_RAMP_EN
    localparam logic [W:0] STEP = (W+1)'(RAMP_STEP);

    logic [W:0] tgt_phi_reg;

    // Move cur toward tgt by at most STEP and never past it.
    function automatic logic [W:0] ramp_toward(input logic [W:0] cur, input logic [W:0] tgt);
        if (cur < tgt)
            ramp_toward = ((tgt - cur) > STEP) ? cur + STEP : tgt;
        else
            ramp_toward = ((cur - tgt) > STEP) ? cur - STEP : tgt;
    endfunction
`endif

    // Counter landmarks for the active set. 2N is held at W+1 bits, so it cannot overflow.
    assign two_n     = {act_n_reg, 1'b0};
    assign last_cnt  = two_n - 1'b1;
    assign half_last = {1'b0, act_n_reg} - 1'b1;
    assign at_wrap   = (cnt_reg == last_cnt);
    assign at_half   = (cnt_reg == half_last);
    assign cnt_inc   = at_wrap ? '0 : cnt_reg + 1'b1;

    // Handshake and promotion qualifiers.
    assign cfg_ready = !pend_full_reg;
    assign xfer      = cfg_valid && cfg_ready && ce;
    assign cfg_ok    = (half_period >= N_MIN) && (d1 <= half_period) &&
                       (d2 <= half_period) && (phi < {half_period, 1'b0});
    assign promote   = ce && pend_full_reg && ((state_reg == IDLE) || at_wrap);

    // The secondary position is (cnt - phi) mod 2N. The true result is below
    // 2N <= 2^(W+1), so plain W+1-bit modular arithmetic gives it exactly.
    assign sec_pos = (cnt_reg >= act_phi_reg) ? (cnt_reg - act_phi_reg)
                                              : (cnt_reg + two_n - act_phi_reg);

    // One level decoder per bridge side. Channel 0 is the primary, channel 1 the secondary.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [W:0] pos;
        logic [W:0] dz;
        logic [W:0] n_ext;
        logic [1:0] lvl;

        assign pos   = (gi == 0) ? cnt_reg : sec_pos;
        assign dz    = {1'b0, (gi == 0) ? act_d1_reg : act_d2_reg};
        assign n_ext = {1'b0, act_n_reg};

        // Map position to a level: zero state first, then +1 in the first half and -1 in the second.
        always_comb begin
            if (pos < n_ext)
                lvl = (pos < dz) ? 2'b00 : 2'b01;
            else
                lvl = (pos < (n_ext + dz)) ? 2'b00 : 2'b11;
        end
    end

    // Settings path: accept and check offers, then promote pending to active at legal points.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_n_reg     <= '0;
            pend_d1_reg    <= '0;
            pend_d2_reg    <= '0;
            pend_phi_reg   <= '0;
            pend_full_reg  <= 1'b0;
            act_n_reg      <= '0;
            act_d1_reg     <= '0;
            act_d2_reg     <= '0;
            act_phi_reg    <= '0;
            act_loaded_reg <= 1'b0;
            cfg_err_reg    <= 1'b0;
`ifdef PHASE_RAMP_EN
            tgt_phi_reg    <= '0;
`endif
        end else if (ce) begin
            if (xfer) begin
                if (cfg_ok) begin
                    pend_n_reg    <= half_period;
                    pend_d1_reg   <= d1;
                    pend_d2_reg   <= d2;
                    pend_phi_reg  <= phi;
                    pend_full_reg <= 1'b1;
                    cfg_err_reg   <= 1'b0;
                end else begin
                    cfg_err_reg   <= 1'b1;
                end
            end
            if (promote) begin
                // Promotion reads the old pending contents. A setting accepted in
                // the same cycle keeps pending full.
                act_n_reg      <= pend_n_reg;
                act_d1_reg     <= pend_d1_reg;
                act_d2_reg     <= pend_d2_reg;
                act_loaded_reg <= 1'b1;
                if (!(xfer && cfg_ok))
                    pend_full_reg <= 1'b0;
`ifdef PHASE_RAMP_EN
                tgt_phi_reg    <= pend_phi_reg;
                act_phi_reg    <= (state_reg == IDLE) ? pend_phi_reg
                                                      : ramp_toward(act_phi_reg, pend_phi_reg);
            end else if (running && at_wrap) begin
                act_phi_reg    <= ramp_toward(act_phi_reg, tgt_phi_reg);
`else
                act_phi_reg    <= pend_phi_reg;
`endif
            end
        end
    end

    // FSM state register and period counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else if (ce) begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic. STOP keeps switching until a half boundary, so a half cycle is never cut short.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (en && act_loaded_reg)
                    state_next = RUN;
            end
            RUN: begin
                cnt_next = cnt_inc;
                if (!en)
                    state_next = STOP;
            end
            STOP: begin
                if (en) begin
                    state_next = RUN;
                    cnt_next   = cnt_inc;
                end else if (at_wrap || at_half) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode. Levels are driven only while switching, and 00 otherwise.
    always_comb begin
        running = (state_reg == RUN) || (state_reg == STOP);
        v1_next = running ? g_ch[0].lvl : 2'b00;
        v2_next = running ? g_ch[1].lvl : 2'b00;
        ps_next = running && (cnt_reg == '0);
    end

    // Registered level commands, one ce-cycle behind the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg <= 2'b00;
            v2_reg <= 2'b00;
            ps_reg <= 1'b0;
        end else if (ce) begin
            v1_reg <= v1_next;
            v2_reg <= v2_next;
            ps_reg <= ps_next;
        end
    end

    assign V1           = v1_reg;
    assign V2           = v2_reg;
    assign period_start = ps_reg;
    assign cfg_err      = cfg_err_reg;

endmodule

// File: tb/tb_phase_shift_modulator.sv
// Directed bench for phase_shift_modulator in its default build. Table
// vectors cover the basic TPS waveform. Hand-written sequences cover
// boundary-aligned updates, rejected settings, stop/restart, ce gating and reset.
module tb_phase_shift_modulator;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, ce, en, cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] half_period, d1, d2;
    logic [W:0]   phi;
    logic         cfg_err;
    logic [1:0]   V1, V2;
    logic         period_start, running;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    phase_shift_modulator #(.W(W)) dut (
        .clk(clk), .rst(rst), .ce(ce), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .half_period(half_period), .d1(d1), .d2(d2), .phi(phi),
        .cfg_err(cfg_err), .V1(V1), .V2(V2),
        .period_start(period_start), .running(running)
    );

    typedef struct {
        logic [1:0] v1;
        logic [1:0] v2;
        logic       ps;
    } vec_t;

    vec_t tbl [20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one setting for a single ce cycle.
    task automatic offer(input int n, input int a, input int b, input int p);
        half_period = W'(n);
        d1          = W'(a);
        d2          = W'(b);
        phi         = (W+1)'(p);
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        $display("cfg offer N=%0d d1=%0d d2=%0d phi=%0d -> ready=%0b err=%0b",
                 n, a, b, p, cfg_ready, cfg_err);
    endtask

    // Count cycles until the next period_start, bounded.
    task automatic wait_ps(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < 200);
        if (!period_start) begin
            checks++;
            failures++;
            $display("FAIL wait_ps_timeout: no period_start within %0d cycles", n);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int edges;
        logic prev;

        rst = 1'b1; ce = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        half_period = '0; d1 = '0; d2 = '0; phi = '0;

        // Expected levels for N=10, d1=2, d2=3, phi=5, indexed by cnt.
        for (int k = 0; k < 20; k++) begin
            tbl[k].v1 = (k < 2) ? 2'b00 : (k < 10) ? 2'b01 : (k < 12) ? 2'b00 : 2'b11;
            tbl[k].v2 = (k < 5) ? 2'b11 : (k < 8) ? 2'b00 : (k < 15) ? 2'b01 :
                        (k < 18) ? 2'b00 : 2'b11;
            tbl[k].ps = (k == 0);
        end

        tick(); tick();
        chk("rst_v1", V1, 0);
        chk("rst_v2", V2, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_running", running, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        rst = 1'b0;

        // Start-up: transfer at t, promote at t+1, RUN at t+2, first outputs at t+3.
        en = 1'b1;
        offer(10, 2, 3, 5);
        chk("start_ready_t", cfg_ready, 0);
        chk("start_running_t", running, 0);
        tick();
        chk("start_ready_t1", cfg_ready, 1);
        chk("start_running_t1", running, 0);
        tick();
        chk("start_running_t2", running, 1);
        chk("start_ps_t2", period_start, 0);
        for (int k = 0; k < 40; k++) begin
            tick();
            $display("vec %0d cnt=%0d V1=%b V2=%b ps=%b", k, k % 20, V1, V2, period_start);
            chk("tbl_v1", V1, tbl[k % 20].v1);
            chk("tbl_v2", V2, tbl[k % 20].v2);
            chk("tbl_ps", period_start, tbl[k % 20].ps);
        end

        // Boundary-aligned update: offer N=8 when the counter is at 3.
        tick(); tick(); tick();
        offer(8, 2, 3, 5);
        chk("upd_ready_low", cfg_ready, 0);
        chk("upd_v1_cnt3", V1, 2'b01);
        repeat (15) tick();
        chk("upd_ready_before_wrap", cfg_ready, 0);
        chk("upd_ps_before_wrap", period_start, 0);
        tick();
        chk("upd_ready_at_wrap", cfg_ready, 1);
        chk("upd_v1_cnt19_old", V1, 2'b11);
        tick();
        chk("upd_ps_new", period_start, 1);
        chk("upd_v1_new_cnt0", V1, 2'b00);
        chk("upd_v2_new_cnt0", V2, 2'b11);
        wait_ps(n); chk("upd_period16_a", n, 16);
        wait_ps(n); chk("upd_period16_b", n, 16);

        // Rejected settings leave the active waveform alone.
        offer(10, 11, 3, 5);
        chk("rej_d1_err", cfg_err, 1);
        chk("rej_d1_ready", cfg_ready, 1);
        offer(10, 2, 3, 20);
        chk("rej_phi_err", cfg_err, 1);
        chk("rej_phi_ready", cfg_ready, 1);
        offer(1, 0, 0, 0);
        chk("rej_n_err", cfg_err, 1);
        wait_ps(n); chk("rej_partial13", n, 13);
        wait_ps(n); chk("rej_period16", n, 16);
        offer(10, 2, 3, 5);
        chk("ok_err_clear", cfg_err, 0);
        chk("ok_ready_low", cfg_ready, 0);
        wait_ps(n); chk("ok_partial15", n, 15);
        wait_ps(n); chk("ok_period20", n, 20);

        // Stop: en drops at cnt=4. Switching continues through cnt=9, then goes idle.
        tick(); tick(); tick();
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stop_v1", V1, 2'b01);
            chk("stop_running", running, (i < 5) ? 1 : 0);
        end
        tick();
        chk("stop_idle_v1", V1, 0);
        chk("stop_idle_v2", V2, 0);
        chk("stop_idle_ps", period_start, 0);
        tick(); tick();
        chk("stop_hold_v1", V1, 0);
        chk("stop_hold_running", running, 0);

        // Restart from IDLE with an already-loaded setting.
        en = 1'b1;
        tick();
        chk("restart_running", running, 1);
        chk("restart_ps_wait", period_start, 0);
        tick();
        chk("restart_ps", period_start, 1);
        chk("restart_v2_cnt0", V2, 2'b11);

        // en drops at cnt=4 and returns at cnt=7: the period must stay 20 counts.
        tick(); tick(); tick();
        en = 1'b0;
        tick(); tick(); tick();
        en = 1'b1;
        wait_ps(n); chk("nogap_rest14", n, 14);
        chk("nogap_running", running, 1);
        wait_ps(n); chk("nogap_period20", n, 20);

        // ce at 50%: period measured between rising edges of period_start.
        prev = period_start; n = 0; edges = 0;
        for (int i = 0; i < 200 && edges < 2; i++) begin
            ce = ~ce;
            tick();
            if (edges == 1) n++;
            if (period_start && !prev) edges++;
            prev = period_start;
        end
        chk("ce_edges", edges, 2);
        chk("ce_period40", n, 40);
        ce = 1'b1;
        wait_ps(n); chk("ce_back_period20", n, 20);

        // Reset in the middle of a period while a setting is pending.
        offer(10, 2, 3, 5);
        tick(); tick(); tick();
        chk("prerst_v1", V1, 2'b01);
        chk("prerst_ready", cfg_ready, 0);
        rst = 1'b1;
        tick();
        chk("midrst_v1", V1, 0);
        chk("midrst_v2", V2, 0);
        chk("midrst_ps", period_start, 0);
        chk("midrst_running", running, 0);
        chk("midrst_cfg_err", cfg_err, 0);
        chk("midrst_ready", cfg_ready, 1);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("postrst_running", running, 0);
        chk("postrst_v1", V1, 0);

        // Boundaries: d1=0 gives a square wave, and d2=N gives constant 00.
        offer(4, 0, 4, 0);
        chk("sq_err", cfg_err, 0);
        tick(); tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            $display("sq %0d cnt=%0d V1=%b V2=%b ps=%b", k, k % 8, V1, V2, period_start);
            chk("sq_v1", V1, ((k % 8) < 4) ? 2'b01 : 2'b11);
            chk("sq_v2", V2, 2'b00);
            chk("sq_ps", period_start, ((k % 8) == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
